// File: rtl/pc_fetch_sequencer_pkg.sv
// Purpose: shared widths, NPC op / FSM encodings and the fetch-word payload
//          type for the IF-stage fetch sequencer.
// Ports:   none (package).
package pc_fetch_sequencer_pkg;

    localparam int unsigned PC_W   = 30;
    localparam int unsigned INST_W = 32;
    localparam int unsigned OFF_W  = 16;
    localparam int unsigned IDX_W  = 26;
    localparam int unsigned OP_W   = 2;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [OP_W-1:0] {
        NPC_NORMAL = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_RF     = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_DRAIN = 2'b10,
        S_HOLD  = 2'b11
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_word_t;

    // Sign-extend a 16-bit word offset to PC width.
    function automatic logic [PC_W-1:0] sext_off(input logic [OFF_W-1:0] off);
        return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Purpose: next-PC priority mux and target arithmetic (combinational).
//          Priority: EX branch > ID jr > ID jump > sequential; ID sources
//          are ignored while stalled.
// Ports:   stall, br_taken, br_pc, br_off, jmp, jr, id_pc, jmp_idx, jr_tgt,
//          seq_pc (current PC) in; npc_op, target, redirect out.
module pc_target_sel
    import pc_fetch_sequencer_pkg::*;
(
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              jmp,
    input  logic              jr,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [IDX_W-1:0]  jmp_idx,
    input  logic [INST_W-1:0] jr_tgt,
    input  logic [PC_W-1:0]   seq_pc,
    output npc_op_e           npc_op,
    output logic [PC_W-1:0]   target,
    output logic              redirect
);

    // Byte-offset bits of jr and the low bits of the ID PC carry no target info.
    logic unused_bits;
    assign unused_bits = ^{jr_tgt[1:0], id_pc[PC_W-5:0]};

    always_comb begin
        npc_op = NPC_NORMAL;
        target = seq_pc + PC_W'(1);
        if (br_taken) begin
            npc_op = NPC_BRANCH;
            target = br_pc + sext_off(br_off);
        end else if (!stall && jr) begin
            npc_op = NPC_RF;
            target = jr_tgt[INST_W-1:2];
        end else if (!stall && jmp) begin
            npc_op = NPC_JUMP;
            target = {id_pc[PC_W-1:PC_W-4], jmp_idx};
        end
    end

    assign redirect = (npc_op != NPC_NORMAL);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Purpose: owns the fetch PC, runs the imem request/ready handshake, drops
//          in-flight words on redirect and holds one word while IF/ID stalls.
// Ports:   clk, rst (sync, active high); hazard stall_i; EX branch
//          br_taken_i/br_pc_i/br_off_i; ID jmp_i/jr_i/id_pc_i/jmp_idx_i/jr_tgt_i;
//          imem imem_req_o/imem_addr_o/imem_ready_i/imem_rdata_i;
//          IF/ID pc_o/inst_o/fetch_valid_o; npc_op_o; flush_if_id_o/flush_id_ex_o.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [PC_W-1:0]   br_pc_i,
    input  logic [OFF_W-1:0]  br_off_i,
    input  logic              jmp_i,
    input  logic              jr_i,
    input  logic [PC_W-1:0]   id_pc_i,
    input  logic [IDX_W-1:0]  jmp_idx_i,
    input  logic [INST_W-1:0] jr_tgt_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              fetch_valid_o,
    output logic [OP_W-1:0]   npc_op_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o
);

    state_e          state;
    state_e          state_nxt;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pend_r;
    fetch_word_t     buf_r;

    npc_op_e         npc_op;
    logic [PC_W-1:0] target;
    logic            redirect;

    pc_target_sel u_sel (
        .stall    (stall_i),
        .br_taken (br_taken_i),
        .br_pc    (br_pc_i),
        .br_off   (br_off_i),
        .jmp      (jmp_i),
        .jr       (jr_i),
        .id_pc    (id_pc_i),
        .jmp_idx  (jmp_idx_i),
        .jr_tgt   (jr_tgt_i),
        .seq_pc   (pc_r),
        .npc_op   (npc_op),
        .target   (target),
        .redirect (redirect)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the buffer is full exactly when in S_HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ: begin
                if (redirect && !imem_ready_i)              state_nxt = S_DRAIN;
                else if (imem_ready_i && !redirect && stall_i) state_nxt = S_HOLD;
            end
            S_DRAIN: if (imem_ready_i)                      state_nxt = S_REQ;
            S_HOLD:  if (redirect || !stall_i)              state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; redirect-cycle op and flushes are combinational, masked in reset.
    always_comb begin
        imem_req_o    = (state == S_REQ) || (state == S_DRAIN);
        imem_addr_o   = pc_r;
        pc_o          = pc_r;
        inst_o        = imem_rdata_i;
        fetch_valid_o = 1'b0;
        npc_op_o      = NPC_NORMAL;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        if (!rst) begin
            npc_op_o      = npc_op;
            flush_if_id_o = redirect;
            flush_id_ex_o = (npc_op == NPC_BRANCH);
            case (state)
                S_REQ:   fetch_valid_o = imem_ready_i && !stall_i && !redirect;
                S_HOLD: begin
                    pc_o          = buf_r.pc;
                    inst_o        = buf_r.inst;
                    fetch_valid_o = !stall_i && !redirect;
                end
                default: fetch_valid_o = 1'b0;
            endcase
        end
    end

    // PC, pending redirect target and skid buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r   <= RESET_PC[31:2];
            pend_r <= '0;
            buf_r  <= '0;
        end else begin
            case (state)
                S_IDLE: if (redirect) pc_r <= target;
                S_REQ: begin
                    if (imem_ready_i) begin
                        // target is pc_r+1 when there is no redirect
                        pc_r <= target;
                        if (!redirect && stall_i) begin
                            buf_r.pc   <= pc_r;
                            buf_r.inst <= imem_rdata_i;
                        end
                    end else if (redirect) begin
                        pend_r <= target;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready_i) pc_r   <= redirect ? target : pend_r;
                    else if (redirect) pend_r <= target;
                end
                S_HOLD: if (redirect) pc_r <= target;
                default: pc_r <= pc_r;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Purpose: scoreboard bench for pc_fetch_sequencer. A driver issues directed
//          then random stimulus and queues the expected redirect response; a
//          monitor pops it each cycle and checks ops, flushes and the
//          delivered instruction stream against an architectural PC model.
module tb_pc_fetch_sequencer;

    localparam logic [29:0] RESET_W = 30'h0C00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [29:0] br_pc_i = '0;
    logic [15:0] br_off_i = '0;
    logic        jmp_i = 1'b0;
    logic        jr_i = 1'b0;
    logic [29:0] id_pc_i = '0;
    logic [25:0] jmp_idx_i = '0;
    logic [31:0] jr_tgt_i = '0;
    logic        imem_req_o;
    logic [29:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_rdata_i;
    logic [29:0] pc_o;
    logic [31:0] inst_o;
    logic        fetch_valid_o;
    logic [1:0]  npc_op_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_pc_i       (br_pc_i),
        .br_off_i      (br_off_i),
        .jmp_i         (jmp_i),
        .jr_i          (jr_i),
        .id_pc_i       (id_pc_i),
        .jmp_idx_i     (jmp_idx_i),
        .jr_tgt_i      (jr_tgt_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .fetch_valid_o (fetch_valid_o),
        .npc_op_o      (npc_op_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o)
    );

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, a[1:0]} ^ 32'hA5A5_0F0F;
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    int n_vec  = 0;
    int n_bad  = 0;
    int n_deliv = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  op;
        logic        fif;
        logic        fex;
        logic [29:0] tgt;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [29:0] bpc;
        logic [15:0] boff;
        logic        jmp;
        logic        jr;
        logic [29:0] ipc;
        logic [25:0] idx;
        logic [31:0] jt;
        logic        rdy;
    } stim_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t nop(input logic rdy);
        stim_t s;
        s.rst = 1'b0; s.stall = 1'b0; s.br = 1'b0; s.bpc = '0; s.boff = '0;
        s.jmp = 1'b0; s.jr = 1'b0; s.ipc = '0; s.idx = '0; s.jt = '0; s.rdy = rdy;
        return s;
    endfunction

    // Apply one cycle of stimulus and queue the expected redirect response.
    task automatic step(input stim_t s);
        exp_t e;
        int   t;
        @(posedge clk);
        #1;
        rst        = s.rst;
        stall_i    = s.stall;
        br_taken_i = s.br;
        br_pc_i    = s.bpc;
        br_off_i   = s.boff;
        jmp_i      = s.jmp;
        jr_i       = s.jr;
        id_pc_i    = s.ipc;
        jmp_idx_i  = s.idx;
        jr_tgt_i   = s.jt;
        imem_ready_i = s.rdy & imem_req_o;
        e.rst = s.rst; e.stall = s.stall;
        e.op = 2'b00; e.fif = 1'b0; e.fex = 1'b0; e.tgt = '0;
        if (!s.rst) begin
            if (s.br) begin
                t = int'(s.bpc) + int'($signed(s.boff));
                e.op = 2'b01; e.fif = 1'b1; e.fex = 1'b1; e.tgt = 30'(t);
            end else if (!s.stall && s.jr) begin
                e.op = 2'b11; e.fif = 1'b1; e.tgt = 30'(s.jt / 4);
            end else if (!s.stall && s.jmp) begin
                t = ((int'(s.ipc) >> 26) << 26) + int'(s.idx);
                e.op = 2'b10; e.fif = 1'b1; e.tgt = 30'(t);
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: architectural model is "next delivered word is exp_pc".
    exp_t        me;
    logic [29:0] exp_pc    = RESET_W;
    logic        have_prev = 1'b0;
    logic        prev_req, prev_rdy, prev_rst;
    logic [29:0] prev_addr;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            check("npc_op", 32'(npc_op_o), 32'(me.op));
            check("flush_if_id", 32'(flush_if_id_o), 32'(me.fif));
            check("flush_id_ex", 32'(flush_id_ex_o), 32'(me.fex));
            if (me.rst) begin
                check("valid_in_reset", 32'(fetch_valid_o), 32'(0));
                exp_pc = RESET_W;
            end else begin
                if (me.stall) check("valid_while_stall", 32'(fetch_valid_o), 32'(0));
                if (me.fif) begin
                    check("valid_on_flush", 32'(fetch_valid_o), 32'(0));
                    exp_pc = me.tgt;
                end else if (fetch_valid_o === 1'b1) begin
                    check("pc_stream", 32'(pc_o), 32'(exp_pc));
                    check("inst_stream", inst_o, mem_word(exp_pc));
                    exp_pc = exp_pc + 30'd1;
                    n_deliv++;
                end
            end
            if (have_prev && prev_req === 1'b1 && prev_rdy === 1'b0 && prev_rst === 1'b0)
                check("addr_hold", 32'(imem_addr_o), 32'(prev_addr));
            prev_req  = imem_req_o;
            prev_rdy  = imem_ready_i;
            prev_rst  = me.rst;
            prev_addr = imem_addr_o;
            have_prev = 1'b1;
        end
    end

    initial begin
        stim_t d;
        // Reset held two cycles.
        d = nop(1'b0); d.rst = 1'b1;
        step(d);
        step(d);
        #2;
        check("reset_req", 32'(imem_req_o), 32'(0));
        check("reset_valid", 32'(fetch_valid_o), 32'(0));
        step(nop(1'b0));
        // First request after release; sequential back-to-back fetches.
        step(nop(1'b1));
        #2;
        check("first_req", 32'(imem_req_o), 32'(1));
        check("first_addr", 32'(imem_addr_o), 32'(30'h0C00));
        check("seq0_valid", 32'(fetch_valid_o), 32'(1));
        check("seq0_pc", 32'(pc_o), 32'(30'h0C00));
        step(nop(1'b1));
        #2;
        check("seq1_addr", 32'(imem_addr_o), 32'(30'h0C01));
        check("seq1_pc", 32'(pc_o), 32'(30'h0C01));
        step(nop(1'b1));
        #2;
        check("seq2_addr", 32'(imem_addr_o), 32'(30'h0C02));
        check("seq2_valid", 32'(fetch_valid_o), 32'(1));
        // Backward branch with ready in the same cycle.
        d = nop(1'b1); d.br = 1'b1; d.bpc = 30'h0C05; d.boff = 16'hFFFE;
        step(d);
        #2;
        check("br_op", 32'(npc_op_o), 32'(2'b01));
        check("br_flush_ex", 32'(flush_id_ex_o), 32'(1));
        check("br_valid", 32'(fetch_valid_o), 32'(0));
        step(nop(1'b1));
        #2;
        check("br_next_addr", 32'(imem_addr_o), 32'(30'h0C03));
        // Branch beats a same-cycle jump.
        d = nop(1'b1); d.br = 1'b1; d.bpc = 30'h0100; d.boff = 16'h0004;
        d.jmp = 1'b1; d.ipc = 30'h0; d.idx = 26'h0000100;
        step(d);
        #2;
        check("brj_op", 32'(npc_op_o), 32'(2'b01));
        check("brj_flush_ex", 32'(flush_id_ex_o), 32'(1));
        step(nop(1'b1));
        #2;
        check("brj_addr", 32'(imem_addr_o), 32'(30'h0104));
        // Slow imem, then jr while the request is outstanding.
        for (int i = 0; i < 3; i++) begin
            step(nop(1'b0));
            #2;
            check("slow_valid", 32'(fetch_valid_o), 32'(0));
        end
        d = nop(1'b0); d.jr = 1'b1; d.jt = 32'h0000_4000;
        step(d);
        #2;
        check("jr_op", 32'(npc_op_o), 32'(2'b11));
        step(nop(1'b0));
        #2;
        check("drain_addr_held", 32'(imem_addr_o), 32'(30'h0105));
        check("drain_req", 32'(imem_req_o), 32'(1));
        step(nop(1'b1));
        #2;
        check("drain_word_dropped", 32'(fetch_valid_o), 32'(0));
        // Stall while the word at the jr target returns.
        d = nop(1'b1); d.stall = 1'b1;
        step(d);
        #2;
        check("jr_next_addr", 32'(imem_addr_o), 32'(30'h1000));
        step(d);
        #2;
        check("hold_req", 32'(imem_req_o), 32'(0));
        step(nop(1'b0));
        #2;
        check("hold_release_valid", 32'(fetch_valid_o), 32'(1));
        check("hold_release_pc", 32'(pc_o), 32'(30'h1000));
        check("hold_release_inst", inst_o, mem_word(30'h1000));
        step(nop(1'b1));
        #2;
        check("after_hold_addr", 32'(imem_addr_o), 32'(30'h1001));
        // Reset while draining discards the pending target.
        d = nop(1'b0); d.br = 1'b1; d.bpc = 30'h2000;
        step(d);
        d = nop(1'b0); d.rst = 1'b1;
        step(d);
        step(nop(1'b0));
        #2;
        check("drain_rst_req", 32'(imem_req_o), 32'(0));
        step(nop(1'b0));
        #2;
        check("drain_rst_addr", 32'(imem_addr_o), 32'(30'h0C00));
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            d.rst   = ($urandom_range(0, 199) == 0);
            d.stall = ($urandom_range(0, 3) == 0);
            d.br    = ($urandom_range(0, 9) == 0);
            d.bpc   = 30'($urandom);
            d.boff  = 16'($urandom);
            d.jmp   = ($urandom_range(0, 9) == 0);
            d.jr    = ($urandom_range(0, 11) == 0);
            d.ipc   = 30'($urandom);
            d.idx   = 26'($urandom);
            d.jt    = $urandom;
            d.rdy   = ($urandom_range(0, 3) != 0);
            step(d);
        end
        step(nop(1'b0));
        @(posedge clk);
        @(negedge clk);
        #1;
        check("stream_progress", 32'(n_deliv > 300), 32'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
